logic_unit_pipe: RTL and testbench

- Parametrised, registered successor to the single-bit gate blocks: a WIDTH-bit bitwise logic unit with runtime-selectable operation.
- Inputs are accepted over a valid/ready handshake, computed in one cycle, and held in a 2-entry output buffer.
- Sustains full throughput under intermittent backpressure; feeds the ALU/datapath stages of the computer build.

---
 rtl/logic_unit_pkg.sv | 29 ++
 rtl/logic_op_core.sv | 51 +++++
 rtl/logic_unit_pipe.sv | 166 ++++++++++++++++
 tb/tb_logic_unit_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_pkg
//
// Purpose: shared definitions for the registered logic unit pipeline.
//   - lu_op_e  : 3-bit operation select encoding (OP_AND .. OP_PASS)
//   - LU_DEPTH : number of entries in the output buffer
//   - LU_CNT_W : width of the buffer occupancy counter
//
// No ports; imported by logic_op_core and logic_unit_pipe.
// -----------------------------------------------------------------------------
package logic_unit_pkg;

  // Operation select. All eight codes are meaningful; there is no illegal op.
  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } lu_op_e;

  // Output buffer depth and the counter width needed to hold 0..LU_DEPTH.
  localparam int LU_DEPTH = 2;
  localparam int LU_CNT_W = $clog2(LU_DEPTH + 1);

endpackage

// File: rtl/logic_op_core.sv
// -----------------------------------------------------------------------------
// logic_op_core
//
// Purpose: purely combinational WIDTH-bit bitwise logic operation plus
// all-zeros / all-ones flags on the result.
//
// Parameters:
//   WIDTH  - operand/result width in bits
//
// Ports:
//   op      in   3      operation select (lu_op_e encoding)
//   in0     in   WIDTH  operand A
//   in1     in   WIDTH  operand B (ignored for NOT and PASS)
//   result  out  WIDTH  operation result
//   zero    out  1      result is all zeros
//   ones    out  1      result is all ones
// -----------------------------------------------------------------------------
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ones
);

  // Operation decode; NOT and PASS only look at in0.
  always_comb begin
    result = '0;
    case (lu_op_e'(op))
      OP_AND:  result = in0 & in1;
      OP_OR:   result = in0 | in1;
      OP_NAND: result = ~(in0 & in1);
      OP_NOR:  result = ~(in0 | in1);
      OP_XOR:  result = in0 ^ in1;
      OP_XNOR: result = ~(in0 ^ in1);
      OP_NOT:  result = ~in0;
      OP_PASS: result = in0;
      default: result = in0;
    endcase
  end

  // Flags are derived from the finished result so they travel with it.
  assign zero = ~|result;
  assign ones = &result;

endmodule

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//
// Purpose: registered WIDTH-bit bitwise logic unit with a valid/ready input
// handshake and a 2-entry output buffer. A result is computed in the accept
// cycle and written into the buffer at the accept edge; out/out_zero/out_ones
// always come from the registered head entry.
//
// Parameters:
//   WIDTH  - operand/result width (1..64)
//   CNT_W  - width of the optional pop counter
//
// Optional feature (macro LOGIC_UNIT_COUNT_EN):
//   defined   -> op_count port present, counts pops, wraps, cleared by rst_n
//   undefined -> op_count port and counter are absent
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands and op are valid
//   in_ready   out  1      unit can accept (buffer not full)
//   op         in   3      operation select
//   in0        in   WIDTH  operand A
//   in1        in   WIDTH  operand B
//   out_valid  out  1      head result is valid
//   out_ready  in   1      consumer takes head result
//   out        out  WIDTH  head result
//   out_zero   out  1      head result is all zeros
//   out_ones   out  1      head result is all ones
//   op_count   out  CNT_W  completed pops (LOGIC_UNIT_COUNT_EN only)
// -----------------------------------------------------------------------------
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_ones
`ifdef LOGIC_UNIT_COUNT_EN
  ,
  output logic [CNT_W-1:0] op_count
`endif
);

  localparam logic [LU_CNT_W-1:0] CNT_EMPTY = '0;
  localparam logic [LU_CNT_W-1:0] CNT_ONE   = LU_CNT_W'(1);
  localparam logic [LU_CNT_W-1:0] CNT_FULL  = LU_CNT_W'(LU_DEPTH);

  // Elaboration-time sanity check on the parameter ranges.
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("logic_unit_pipe: WIDTH must be in 1..64");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("logic_unit_pipe: CNT_W must be at least 1");
  end

  logic [WIDTH-1:0]    core_result;
  logic                core_zero;
  logic                core_ones;

  // Buffer state: head entry drives the outputs directly, tail is the
  // second slot that only holds data while the buffer is full.
  logic [LU_CNT_W-1:0] count;
  logic [WIDTH-1:0]    head_data;
  logic                head_zero;
  logic                head_ones;
  logic [WIDTH-1:0]    tail_data;
  logic                tail_zero;
  logic                tail_ones;

  logic                push;
  logic                pop;

  logic_op_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op     (op),
    .in0    (in0),
    .in1    (in1),
    .result (core_result),
    .zero   (core_zero),
    .ones   (core_ones)
  );

  // Handshake status decodes only the registered count, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (count != CNT_FULL);
  assign out_valid = (count != CNT_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out      = head_data;
  assign out_zero = head_zero;
  assign out_ones = head_ones;

  // Buffer update. A new result goes to the head when the head is free
  // (empty, or being popped with one entry), otherwise to the tail. On a
  // pop from full the tail shifts into the head. When the buffer drains the
  // head registers are left alone so the outputs hold their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= CNT_EMPTY;
      head_data <= '0;
      head_zero <= 1'b0;
      head_ones <= 1'b0;
      tail_data <= '0;
      tail_zero <= 1'b0;
      tail_ones <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == CNT_EMPTY) begin
            head_data <= core_result;
            head_zero <= core_zero;
            head_ones <= core_ones;
          end else begin
            tail_data <= core_result;
            tail_zero <= core_zero;
            tail_ones <= core_ones;
          end
          count <= count + CNT_ONE;
        end
        2'b01: begin
          if (count == CNT_FULL) begin
            head_data <= tail_data;
            head_zero <= tail_zero;
            head_ones <= tail_ones;
          end
          count <= count - CNT_ONE;
        end
        2'b11: begin
          // Push requires not-full and pop requires not-empty, so the
          // buffer holds exactly one entry here: replace it in place.
          head_data <= core_result;
          head_zero <= core_zero;
          head_ones <= core_ones;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef LOGIC_UNIT_COUNT_EN
  // Completed-pop counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (pop) begin
      op_count <= op_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
//
// Self-checking bench for logic_unit_pipe (WIDTH=8, CNT_W=4). A queue holds
// the expected buffer contents; results are computed from the op table with
// plain operators. Counter checks are active when LOGIC_UNIT_COUNT_EN is set.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             out_zero;
  logic             out_ones;
`ifdef LOGIC_UNIT_COUNT_EN
  logic [CNT_W-1:0] op_count;
`endif

  int               checks   = 0;
  int               failures = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               pops     = 0;
  logic [7:0]       all_ops_tab[8] = '{8'h81, 8'hE7, 8'h7E, 8'h18,
                                       8'h66, 8'h99, 8'h3C, 8'hC3};

  logic_unit_pipe #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in0       (in0),
    .in1       (in1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_zero  (out_zero),
    .out_ones  (out_ones)
`ifdef LOGIC_UNIT_COUNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Reference result for one operation, straight from the op table.
  function automatic logic [WIDTH-1:0] refOp(int code, logic [WIDTH-1:0] a,
                                             logic [WIDTH-1:0] b);
    case (code)
      0:       return a & b;
      1:       return a | b;
      2:       return ~(a & b);
      3:       return ~(a | b);
      4:       return a ^ b;
      5:       return ~(a ^ b);
      6:       return ~a;
      default: return a;
    endcase
  endfunction

  // Single comparison point; counts every check and every failure.
  task automatic checkOutput(string tag, logic [63:0] observed, logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Compare every visible output against the reference queue.
  task automatic checkModel(string tag);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'(exp_q.size() != 0));
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'(exp_q.size() != LU_DEPTH));
    if (exp_q.size() != 0) begin
      checkOutput({tag, "_out"}, 64'(out), 64'(exp_q[0]));
      checkOutput({tag, "_zero"}, 64'(out_zero), 64'(exp_q[0] == '0));
      checkOutput({tag, "_ones"}, 64'(out_ones), 64'(exp_q[0] == '1));
    end
`ifdef LOGIC_UNIT_COUNT_EN
    checkOutput({tag, "_op_count"}, 64'(op_count), 64'(pops % (1 << CNT_W)));
`endif
  endtask

  // One clock cycle: drive inputs, check at the falling edge, then advance
  // the reference queue at the rising edge (pop first, then push).
  task automatic applyStimulus(string tag, logic v, int o, logic [WIDTH-1:0] a,
                               logic [WIDTH-1:0] b, logic r);
    bit acc;
    bit pp;
    in_valid  = v;
    op        = 3'(o);
    in0       = a;
    in1       = b;
    out_ready = r;
    @(negedge clk);
    checkModel(tag);
    acc = v && (exp_q.size() < LU_DEPTH);
    pp  = r && (exp_q.size() > 0);
    @(posedge clk);
    if (pp) begin
      void'(exp_q.pop_front());
      pops++;
    end
    if (acc) exp_q.push_back(refOp(o, a, b));
    #1;
  endtask

  initial begin
    // Reset held with in_valid asserted: nothing may be accepted.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    op        = 3'd7;
    in0       = 8'hFF;
    in1       = 8'hFF;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out", 64'(out), 64'd0);
    checkOutput("rst_zero", 64'(out_zero), 64'd0);
    checkOutput("rst_ones", 64'(out_ones), 64'd0);
`ifdef LOGIC_UNIT_COUNT_EN
    checkOutput("rst_op_count", 64'(op_count), 64'd0);
`endif
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    checkModel("post_rst");

    // All eight ops on 0xC3/0xA5, each visible one cycle after accept.
    for (int k = 0; k < 8; k++) begin
      applyStimulus("all_ops", 1'b1, k, 8'hC3, 8'hA5, 1'b1);
      checkOutput($sformatf("all_ops_%0d", k), 64'(out), 64'(all_ops_tab[k]));
      checkOutput($sformatf("all_ops_valid_%0d", k), 64'(out_valid), 64'd1);
    end

    // Flag corner cases.
    applyStimulus("flag_and", 1'b1, OP_AND, 8'hF0, 8'h0F, 1'b1);
    checkOutput("flag_and_out", 64'(out), 64'h00);
    checkOutput("flag_and_zero", 64'(out_zero), 64'd1);
    checkOutput("flag_and_ones", 64'(out_ones), 64'd0);
    applyStimulus("flag_or", 1'b1, OP_OR, 8'hF0, 8'h0F, 1'b1);
    checkOutput("flag_or_out", 64'(out), 64'hFF);
    checkOutput("flag_or_ones", 64'(out_ones), 64'd1);
    checkOutput("flag_or_zero", 64'(out_zero), 64'd0);
    applyStimulus("drain0", 1'b0, 0, 8'h00, 8'h00, 1'b1);

    // Backpressure: two accepts fill the buffer, the third must wait.
    applyStimulus("bp1", 1'b1, OP_XOR, 8'h11, 8'h22, 1'b0);
    applyStimulus("bp2", 1'b1, OP_OR, 8'h33, 8'h44, 1'b0);
    checkOutput("bp_full_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_full_out", 64'(out), 64'h33);
    applyStimulus("bp3_blocked", 1'b1, OP_NAND, 8'h55, 8'h66, 1'b1);
    checkOutput("bp_after_pop_in_ready", 64'(in_ready), 64'd1);
    checkOutput("bp_after_pop_out", 64'(out), 64'h77);
    applyStimulus("bp3_accept", 1'b1, OP_NAND, 8'h55, 8'h66, 1'b1);
    applyStimulus("bp_drain1", 1'b0, 0, 8'h00, 8'h00, 1'b1);
    checkOutput("bp_third_out", 64'(out), 64'hBB);
    applyStimulus("bp_drain2", 1'b0, 0, 8'h00, 8'h00, 1'b1);
    checkOutput("bp_empty_valid", 64'(out_valid), 64'd0);

    // Streaming at count=1: one result per cycle, buffer never fills.
    for (int k = 0; k < 10; k++) begin
      applyStimulus("stream", 1'b1, int'($urandom_range(0, 7)),
                    8'($urandom), 8'($urandom), 1'b1);
      checkOutput("stream_valid", 64'(out_valid), 64'd1);
      checkOutput("stream_in_ready", 64'(in_ready), 64'd1);
    end
    applyStimulus("stream_drain", 1'b0, 0, 8'h00, 8'h00, 1'b1);

    // Randomised traffic with intermittent backpressure.
    for (int k = 0; k < 400; k++) begin
      applyStimulus("rand", 1'($urandom), int'($urandom_range(0, 7)),
                    8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    applyStimulus("rand_drain1", 1'b0, 0, 8'h00, 8'h00, 1'b1);
    applyStimulus("rand_drain2", 1'b0, 0, 8'h00, 8'h00, 1'b1);

    // Reset mid-stream with two entries buffered.
    applyStimulus("mr_fill1", 1'b1, OP_PASS, 8'hA1, 8'h00, 1'b0);
    applyStimulus("mr_fill2", 1'b1, OP_PASS, 8'hA2, 8'h00, 1'b0);
    checkOutput("mr_full_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mr_in_ready", 64'(in_ready), 64'd1);
`ifdef LOGIC_UNIT_COUNT_EN
    checkOutput("mr_op_count", 64'(op_count), 64'd0);
`endif
    exp_q.delete();
    pops = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkModel("mr_post");

    // 17 pops with a 4-bit counter must wrap to 1.
    for (int k = 0; k < 17; k++) begin
      applyStimulus("wrap", 1'b1, int'($urandom_range(0, 7)),
                    8'($urandom), 8'($urandom), 1'b1);
    end
    applyStimulus("wrap_drain", 1'b0, 0, 8'h00, 8'h00, 1'b1);
`ifdef LOGIC_UNIT_COUNT_EN
    checkOutput("wrap_op_count", 64'(op_count), 64'd1);
`endif
    checkOutput("wrap_empty", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
